// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed scan sequencer for an 8-position active-low display bank.
// Optional anti-ghost blanking between positions: define SCAN_BLANK_EN.
module digit_scan_ctrl #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] digit_mask,
  output logic [2:0] sel,
  output logic [7:0] sel_n,
  output logic       frame_done
);

  localparam int MAXC = (CLK_DIV > BLANK_CYCLES)
                      ? CLK_DIV : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC);

  localparam logic [CW-1:0] DWELL_END = CW'(CLK_DIV - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
`ifdef SCAN_BLANK_EN
    BLANK,
`endif
    IDLE,
    SCAN
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [2:0]      sel_d;
  logic [7:0]      sel_n_d;
  logic            fd_d;
  logic [2:0]      nxt;
  logic            load;
  logic            go_idle;

  function automatic logic [2:0] lowest(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Rotate so bit 0 is cur+1; the lowest set bit is the wrap-around search.
  function automatic logic [2:0] next_pos(
    input logic [2:0] cur,
    input logic [7:0] m
  );
    logic [15:0] dbl;
    logic [7:0]  rot;
    dbl = {m, m};
    rot = 8'(dbl >> (4'(cur) + 4'd1));
    return cur + 3'd1 + lowest(rot);
  endfunction

  function automatic logic [7:0] dec_n(input logic [2:0] p);
    return ~(8'b1 << p);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= 3'd0;
      sel_n      <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      sel        <= sel_d;
      sel_n      <= sel_n_d;
      frame_done <= fd_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sel_d   = sel;
    sel_n_d = sel_n;
    fd_d    = 1'b0;
    load    = 1'b0;
    go_idle = 1'b0;
    nxt     = next_pos(sel, digit_mask);

    if (!en) begin
      go_idle = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (|digit_mask) begin
            state_d = SCAN;
            sel_d   = lowest(digit_mask);
            sel_n_d = dec_n(lowest(digit_mask));
            cnt_d   = '0;
          end
        end
        SCAN: begin
          if (cnt == DWELL_END) begin
`ifdef SCAN_BLANK_EN
            state_d = BLANK;
            sel_n_d = 8'hFF;
            cnt_d   = '0;
`else
            load    = 1'b1;
`endif
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
`ifdef SCAN_BLANK_EN
        BLANK: begin
          if (cnt == BLANK_END) load = 1'b1;
          else cnt_d = cnt + CW'(1);
        end
`endif
        default: go_idle = 1'b1;
      endcase
    end

    // The mask is only looked at here, so mid-dwell edits never cut a dwell.
    if (load) begin
      if (|digit_mask) begin
        state_d = SCAN;
        sel_d   = nxt;
        sel_n_d = dec_n(nxt);
        cnt_d   = '0;
        fd_d    = (nxt <= sel);
      end else begin
        go_idle = 1'b1;
      end
    end

    if (go_idle) begin
      state_d = IDLE;
      cnt_d   = '0;
      sel_d   = 3'd0;
      sel_n_d = 8'hFF;
      fd_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl (CLK_DIV=4, BLANK_CYCLES=2).
module tb_digit_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int BLANK_CYCLES = 2;
`ifdef SCAN_BLANK_EN
  localparam int BL = BLANK_CYCLES;
`else
  localparam int BL = 0;
`endif
  localparam int STEP = CLK_DIV + BL;

  typedef struct packed {
    logic [2:0] s;
    logic [7:0] sn;
    logic       fd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] digit_mask;
  logic [2:0] sel;
  logic [7:0] sel_n;
  logic       frame_done;

  exp_t q[$];
  exp_t e;
  int   vectors = 0;
  int   errors = 0;

  digit_scan_ctrl #(
    .CLK_DIV(CLK_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .digit_mask(digit_mask),
    .sel(sel),
    .sel_n(sel_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) q.push_back('{3'd0, 8'hFF, 1'b0});
  endtask

  // Expected sequence: enabled positions in ascending order, repeating;
  // the return to the first listed position is the frame wrap.
  task automatic push_scan(input logic [7:0] m, input int ncyc);
    int pos[$];
    int k;
    int target;
    int p;
    int n;
    logic [7:0] one;
    target = q.size() + ncyc;
    for (int i = 0; i < 8; i++) if (m[i]) pos.push_back(i);
    n = pos.size();
    k = 0;
    while (q.size() < target) begin
      if (k > 0) begin
        for (int b = 0; b < BL; b++)
          if (q.size() < target)
            q.push_back('{3'(pos[(k-1) % n]), 8'hFF, 1'b0});
      end
      p = pos[k % n];
      one = 8'b1 << p;
      for (int c = 0; c < CLK_DIV; c++)
        if (q.size() < target)
          q.push_back('{3'(p), ~one,
                        (c == 0 && k > 0 && (k % n) == 0)});
      k++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++;
    if ({sel, sel_n, frame_done} !== {3'd0, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: got %0d/%h/%b want 0/ff/0",
               sel, sel_n, frame_done);
    end
    rst_n = 1'b1;
    en = 1'b1;
    digit_mask = 8'hFF;
    repeat (STEP + 1) @(negedge clk);
    vectors++;
    if ({sel, sel_n} !== {3'd1, 8'hFD}) begin
      errors++;
      $display("FAIL pre_reset: got %0d/%h want 1/fd", sel, sel_n);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({sel, sel_n, frame_done} !== {3'd0, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got %0d/%h/%b want 0/ff/0",
               sel, sel_n, frame_done);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(3);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      vectors++;
      if ({sel, sel_n, frame_done} !== e) begin
        errors++;
        $display("FAIL post_reset: got %0d/%h/%b want %0d/%h/%b",
                 sel, sel_n, frame_done, e.s, e.sn, e.fd);
      end
    end
  endtask

  task automatic test_full_scan;
    en = 1'b1;
    digit_mask = 8'hFF;
    push_scan(8'hFF, 9 * STEP - BL);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      vectors++;
      if ({sel, sel_n, frame_done} !== e) begin
        errors++;
        $display("FAIL full_scan: got %0d/%h/%b want %0d/%h/%b",
                 sel, sel_n, frame_done, e.s, e.sn, e.fd);
      end
    end
    en = 1'b0;
    push_idle(1);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      vectors++;
      if ({sel, sel_n, frame_done} !== e) begin
        errors++;
        $display("FAIL full_scan_stop: got %0d/%h/%b want %0d/%h/%b",
                 sel, sel_n, frame_done, e.s, e.sn, e.fd);
      end
    end
  endtask

  task automatic test_sparse;
    en = 1'b1;
    digit_mask = 8'b1010_0101;
    push_scan(8'b1010_0101, 6 * STEP - BL);
    push_idle(0);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      vectors++;
      if ({sel, sel_n, frame_done} !== e) begin
        errors++;
        $display("FAIL sparse: got %0d/%h/%b want %0d/%h/%b",
                 sel, sel_n, frame_done, e.s, e.sn, e.fd);
      end
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_two_pos;
    en = 1'b1;
    digit_mask = 8'h03;
    push_scan(8'h03, 3 * STEP - BL);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      vectors++;
      if ({sel, sel_n, frame_done} !== e) begin
        errors++;
        $display("FAIL two_pos: got %0d/%h/%b want %0d/%h/%b",
                 sel, sel_n, frame_done, e.s, e.sn, e.fd);
      end
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_en_drop;
    en = 1'b1;
    digit_mask = 8'hFF;
    push_scan(8'hFF, 3 * STEP + 2);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      vectors++;
      if ({sel, sel_n, frame_done} !== e) begin
        errors++;
        $display("FAIL en_run: got %0d/%h/%b want %0d/%h/%b",
                 sel, sel_n, frame_done, e.s, e.sn, e.fd);
      end
    end
    en = 1'b0;
    push_idle(2);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      vectors++;
      if ({sel, sel_n, frame_done} !== e) begin
        errors++;
        $display("FAIL en_drop: got %0d/%h/%b want %0d/%h/%b",
                 sel, sel_n, frame_done, e.s, e.sn, e.fd);
      end
    end
    en = 1'b1;
    push_scan(8'hFF, STEP + 1);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      vectors++;
      if ({sel, sel_n, frame_done} !== e) begin
        errors++;
        $display("FAIL en_restart: got %0d/%h/%b want %0d/%h/%b",
                 sel, sel_n, frame_done, e.s, e.sn, e.fd);
      end
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_corner_masks;
    en = 1'b1;
    digit_mask = 8'h00;
    push_idle(5);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      vectors++;
      if ({sel, sel_n, frame_done} !== e) begin
        errors++;
        $display("FAIL mask_zero: got %0d/%h/%b want %0d/%h/%b",
                 sel, sel_n, frame_done, e.s, e.sn, e.fd);
      end
    end
    digit_mask = 8'h10;
    push_scan(8'h10, 3 * STEP);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      vectors++;
      if ({sel, sel_n, frame_done} !== e) begin
        errors++;
        $display("FAIL mask_single: got %0d/%h/%b want %0d/%h/%b",
                 sel, sel_n, frame_done, e.s, e.sn, e.fd);
      end
    end
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    digit_mask = 8'hFF;
    push_scan(8'hFF, 2);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      vectors++;
      if ({sel, sel_n, frame_done} !== e) begin
        errors++;
        $display("FAIL mask_clr_pre: got %0d/%h/%b want %0d/%h/%b",
                 sel, sel_n, frame_done, e.s, e.sn, e.fd);
      end
    end
    digit_mask = 8'h00;
    q.push_back('{3'd0, 8'hFE, 1'b0});
    q.push_back('{3'd0, 8'hFE, 1'b0});
    push_idle(BL + 2);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      vectors++;
      if ({sel, sel_n, frame_done} !== e) begin
        errors++;
        $display("FAIL mask_clr: got %0d/%h/%b want %0d/%h/%b",
                 sel, sel_n, frame_done, e.s, e.sn, e.fd);
      end
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    digit_mask = 8'h00;
    test_reset();
    test_full_scan();
    test_sparse();
    test_two_pos();
    test_en_drop();
    test_corner_masks();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
